// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: divide sequencer states, result-source and
// forward-select codes, plus the forwarding priority helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } div_state_e;

    // ResultSrc code marking a load in EX
    localparam logic [1:0] ResultSrcLoad = 2'b01;

    // ALU operand forward selects
    localparam logic [1:0] FwdRegFile = 2'b00;
    localparam logic [1:0] FwdMem     = 2'b10;
    localparam logic [1:0] FwdWb      = 2'b01;

    // MEM result wins over WB; x0 never forwards
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd,
                                           input logic       m_we,
                                           input logic [4:0] w_rd,
                                           input logic       w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return FwdMem;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return FwdWb;
        end
        return FwdRegFile;
    endfunction

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Multi-cycle divide sequencer: IDLE -> BUSY -> DONE -> IDLE with a
// down-counter sizing the BUSY phase so start + BUSY span DIV_CYCLES-1 cycles.
module div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic start_hit
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DIV_CYCLES - 2);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: BUSY leaves as the counter reaches zero; DONE ignores start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d   = CntLoad;
                    state_d = (DIV_CYCLES <= 2) ? StDone : StBusy;
                end
            end
            StBusy: begin
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs; start_hit is the combinational start cycle
    always_comb begin
        busy      = (state_q == StBusy);
        done      = (state_q == StDone);
        start_hit = rst_n && (state_q == StIdle) && start;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use stall, branch flush and
// multi-cycle divide freeze of the front end.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] D_Rs1,
    input  logic [4:0] D_Rs2,
    input  logic [4:0] E_Rs1,
    input  logic [4:0] E_Rs2,
    input  logic [4:0] E_Rd,
    input  logic       E_RegWrite,
    input  logic [1:0] E_ResultSrc,
    input  logic       E_PCSrc,
    input  logic       E_DivStart,
    input  logic [4:0] M_Rd,
    input  logic       M_RegWrite,
    input  logic [4:0] W_Rd,
    input  logic       W_RegWrite,
    output logic       F_Stall,
    output logic       D_Stall,
    output logic       E_Stall,
    output logic       D_Flush,
    output logic       E_Flush,
    output logic       M_Flush,
    output logic [1:0] E_ForwardA,
    output logic [1:0] E_ForwardB,
    output logic       E_DivBusy,
    output logic       E_DivDone
);

    logic div_busy, div_done, div_start_hit;
    logic dividing, load_use, redirect;

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (E_DivStart),
        .busy      (div_busy),
        .done      (div_done),
        .start_hit (div_start_hit)
    );

    // Hazard detection; DONE releases everything so the divide advances
    always_comb begin
        dividing = div_start_hit || div_busy;
        load_use = rst_n && !dividing && !div_done && (E_ResultSrc == ResultSrcLoad) &&
                   (E_Rd != 5'd0) && ((E_Rd == D_Rs1) || (E_Rd == D_Rs2));
        redirect = rst_n && !dividing && !div_done && E_PCSrc;
    end

    // Stall/flush outputs; E_RegWrite is not needed by these rules
    always_comb begin
        F_Stall   = dividing || load_use;
        D_Stall   = dividing || load_use;
        E_Stall   = dividing;
        M_Flush   = dividing;
        D_Flush   = redirect;
        E_Flush   = redirect || load_use;
        E_DivBusy = div_busy;
        E_DivDone = div_done;
    end

    // Operand forwarding stays live during a divide
    always_comb begin
        E_ForwardA = fwd_sel(E_Rs1, M_Rd, M_RegWrite, W_Rd, W_RegWrite);
        E_ForwardB = fwd_sel(E_Rs2, M_Rd, M_RegWrite, W_Rd, W_RegWrite);
    end

    logic unused_ok;
    assign unused_ok = E_RegWrite;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run against a cycle-position reference model of the divide.
module tb_hazard_ctrl;

    localparam int DIV = 33;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd;
    logic       E_RegWrite, E_PCSrc, E_DivStart, M_RegWrite, W_RegWrite;
    logic [1:0] E_ResultSrc;
    logic       F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush;
    logic [1:0] E_ForwardA, E_ForwardB;
    logic       E_DivBusy, E_DivDone;

    int passed = 0;
    int total  = 0;

    // Model: cycles elapsed since a divide's start cycle (0 = no divide running)
    int pos;

    hazard_ctrl #(.DIV_CYCLES(DIV), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .E_Rs1(E_Rs1), .E_Rs2(E_Rs2), .E_Rd(E_Rd),
        .E_RegWrite(E_RegWrite), .E_ResultSrc(E_ResultSrc), .E_PCSrc(E_PCSrc),
        .E_DivStart(E_DivStart), .M_Rd(M_Rd), .M_RegWrite(M_RegWrite),
        .W_Rd(W_Rd), .W_RegWrite(W_RegWrite),
        .F_Stall(F_Stall), .D_Stall(D_Stall), .E_Stall(E_Stall),
        .D_Flush(D_Flush), .E_Flush(E_Flush), .M_Flush(M_Flush),
        .E_ForwardA(E_ForwardA), .E_ForwardB(E_ForwardB),
        .E_DivBusy(E_DivBusy), .E_DivDone(E_DivDone)
    );

    always #5 clk = ~clk;

    // Reference divide timeline: start cycle, DIV-2 busy cycles, one done cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pos <= 0;
        else if (pos == 0) pos <= E_DivStart ? 1 : 0;
        else if (pos < DIV - 1) pos <= pos + 1;
        else pos <= 0;
    end

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (M_RegWrite && M_Rd != 0 && M_Rd == rs) return 2'b10;
        if (W_RegWrite && W_Rd != 0 && W_Rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected {F,D,E stall, D,E,M flush, busy, done} from the current inputs
    function automatic logic [7:0] ref_ctrl();
        logic in_div, dn, bsy, lu, br;
        in_div = (pos == 0 && E_DivStart) || (pos >= 1 && pos <= DIV - 2);
        bsy    = (pos >= 1 && pos <= DIV - 2);
        dn     = (pos == DIV - 1);
        lu     = !in_div && !dn && E_ResultSrc == 2'b01 && E_Rd != 0 &&
                 (E_Rd == D_Rs1 || E_Rd == D_Rs2);
        br     = !in_div && !dn && E_PCSrc;
        return {in_div | lu, in_div | lu, in_div, br, br | lu, in_div, bsy, dn};
    endfunction

    task automatic clear_inputs();
        {D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd} = '0;
        {E_RegWrite, E_PCSrc, E_DivStart, M_RegWrite, W_RegWrite} = '0;
        E_ResultSrc = 2'b00;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        E_DivStart = 1'b1; E_PCSrc = 1'b1;
        E_ResultSrc = 2'b01; E_Rd = 5'd3; D_Rs1 = 5'd3;
        #12;
        total++;
        if ({F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, E_DivBusy, E_DivDone}
            !== 8'h00) begin
            $display("FAIL reset_outputs: got %b want 00000000",
                {F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, E_DivBusy, E_DivDone});
        end else passed++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        E_ResultSrc = 2'b01; E_Rd = 5'd5; D_Rs2 = 5'd5; D_Rs1 = 5'd9;
        #1;
        total++;
        if ({F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush} !== 6'b110010) begin
            $display("FAIL load_use_hit: got %b want 110010",
                {F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush});
        end else passed++;
        E_Rd = 5'd0; D_Rs1 = 5'd0;
        #1;
        total++;
        if ({F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush} !== 6'b000000) begin
            $display("FAIL load_use_x0: got %b want 000000",
                {F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush});
        end else passed++;
        // Load-use together with a taken redirect
        E_Rd = 5'd5; E_PCSrc = 1'b1;
        #1;
        total++;
        if ({F_Stall, D_Stall, D_Flush, E_Flush} !== 4'b1111) begin
            $display("FAIL load_use_redirect: got %b want 1111",
                {F_Stall, D_Stall, D_Flush, E_Flush});
        end else passed++;
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        M_Rd = 5'd7; W_Rd = 5'd7; E_Rs1 = 5'd7; E_Rs2 = 5'd7;
        M_RegWrite = 1'b1; W_RegWrite = 1'b1;
        #1;
        total++;
        if (E_ForwardA !== 2'b10) $display("FAIL fwd_a_mem: got %b want 10", E_ForwardA);
        else passed++;
        M_RegWrite = 1'b0;
        #1;
        total++;
        if (E_ForwardA !== 2'b01) $display("FAIL fwd_a_wb: got %b want 01", E_ForwardA);
        else passed++;
        total++;
        if (E_ForwardB !== 2'b01) $display("FAIL fwd_b_wb: got %b want 01", E_ForwardB);
        else passed++;
        E_Rs1 = 5'd0; M_Rd = 5'd0; W_Rd = 5'd0; M_RegWrite = 1'b1;
        #1;
        total++;
        if (E_ForwardA !== 2'b00) $display("FAIL fwd_a_x0: got %b want 00", E_ForwardA);
        else passed++;
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_pcsrc_idle();
        clear_inputs();
        E_PCSrc = 1'b1;
        #1;
        total++;
        if ({D_Flush, E_Flush, F_Stall} !== 3'b110) begin
            $display("FAIL pcsrc_idle: got %b want 110", {D_Flush, E_Flush, F_Stall});
        end else passed++;
        next_cycle();
        E_PCSrc = 1'b0;
        #1;
        total++;
        if ({D_Flush, E_Flush} !== 2'b00) begin
            $display("FAIL pcsrc_release: got %b want 00", {D_Flush, E_Flush});
        end else passed++;
        next_cycle();
    endtask

    task automatic test_divide();
        int bad_stall = 0;
        clear_inputs();
        E_DivStart = 1'b1;
        for (int c = 1; c <= DIV - 1; c++) begin
            #1;
            if ({F_Stall, D_Stall, E_Stall, M_Flush, D_Flush, E_Flush, E_DivDone} !== 7'b1111000
                || E_DivBusy !== (c > 1)) bad_stall++;
            if (c == 10) begin
                E_PCSrc = 1'b1;
                #1;
                total++;
                if ({D_Flush, E_Flush} !== 2'b00) begin
                    $display("FAIL pcsrc_busy: got %b want 00", {D_Flush, E_Flush});
                end else passed++;
                E_PCSrc = 1'b0;
            end
            if (c == 12) begin
                E_Rs2 = 5'd4; M_Rd = 5'd4; M_RegWrite = 1'b1;
                #1;
                total++;
                if (E_ForwardB !== 2'b10) begin
                    $display("FAIL fwd_busy: got %b want 10", E_ForwardB);
                end else passed++;
                E_Rs2 = 5'd0; M_Rd = 5'd0; M_RegWrite = 1'b0;
            end
            next_cycle();
        end
        total++;
        if (bad_stall != 0) $display("FAIL div_stall_cycles: %0d bad cycles want 0", bad_stall);
        else passed++;
        // Cycle DIV: done pulse, everything released
        #1;
        total++;
        if ({E_DivDone, E_DivBusy, F_Stall, D_Stall, E_Stall, M_Flush} !== 6'b100000) begin
            $display("FAIL div_done_cycle: got %b want 100000",
                {E_DivDone, E_DivBusy, F_Stall, D_Stall, E_Stall, M_Flush});
        end else passed++;
        next_cycle();
        E_DivStart = 1'b0;
        #1;
        total++;
        if ({E_DivDone, E_DivBusy, F_Stall, E_Stall} !== 4'b0000) begin
            $display("FAIL div_no_restart: got %b want 0000",
                {E_DivDone, E_DivBusy, F_Stall, E_Stall});
        end else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid_div();
        int stall_cycles = 0;
        int done_at = 0;
        clear_inputs();
        E_DivStart = 1'b1;
        next_cycle();
        E_DivStart = 1'b0;
        for (int c = 2; c < 10; c++) next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({E_DivBusy, E_DivDone, F_Stall, D_Stall, E_Stall, M_Flush} !== 6'b000000) begin
            $display("FAIL reset_mid_div: got %b want 000000",
                {E_DivBusy, E_DivDone, F_Stall, D_Stall, E_Stall, M_Flush});
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        E_DivStart = 1'b1;
        for (int c = 1; c <= 100 && done_at == 0; c++) begin
            #1;
            if (E_Stall) stall_cycles++;
            if (E_DivDone) done_at = c;
            next_cycle();
            E_DivStart = 1'b0;
        end
        total++;
        if (done_at != DIV || stall_cycles != DIV - 1) begin
            $display("FAIL restart_full_count: done at %0d stalls %0d want %0d and %0d",
                done_at, stall_cycles, DIV, DIV - 1);
        end else passed++;
        next_cycle();
    endtask

    task automatic test_random();
        int bad = 0;
        logic [7:0] exp_ctrl;
        for (int i = 0; i < 600; i++) begin
            D_Rs1 = 5'($urandom_range(0, 3)); D_Rs2 = 5'($urandom_range(0, 3));
            E_Rs1 = 5'($urandom_range(0, 3)); E_Rs2 = 5'($urandom_range(0, 3));
            E_Rd  = 5'($urandom_range(0, 3)); M_Rd  = 5'($urandom_range(0, 3));
            W_Rd  = 5'($urandom_range(0, 3));
            E_RegWrite = 1'($urandom); M_RegWrite = 1'($urandom); W_RegWrite = 1'($urandom);
            E_ResultSrc = 2'($urandom);
            E_PCSrc = ($urandom_range(0, 3) == 0);
            E_DivStart = ($urandom_range(0, 15) == 0);
            #2;
            exp_ctrl = ref_ctrl();
            total++;
            if ({F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, E_DivBusy, E_DivDone}
                !== exp_ctrl || E_ForwardA !== ref_fwd(E_Rs1)
                || E_ForwardB !== ref_fwd(E_Rs2)) begin
                bad++;
                if (bad <= 5) begin
                    $display("FAIL random_cycle_%0d: ctrl %b fa %b fb %b want %b %b %b", i,
                        {F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, E_DivBusy,
                         E_DivDone}, E_ForwardA, E_ForwardB, exp_ctrl, ref_fwd(E_Rs1),
                        ref_fwd(E_Rs2));
                end
            end else passed++;
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forwarding();
        test_pcsrc_idle();
        test_divide();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 33, giving the number of EX-stage cycles a multi-cycle divide occupies (legal range 2..63).
REQ-002 SHALL have parameter CNT_W, default 6, giving the width of the divide cycle counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 D_Rs1, D_Rs2  input  5 each  source registers of the instruction in decode.
REQ-007 E_Rs1, E_Rs2, E_Rd  input  5 each  register fields from the ID/EX register.
REQ-008 E_RegWrite  input  1; E_ResultSrc  input  2  (2'b01 = load result).
REQ-009 E_PCSrc  input  1  branch taken or jump resolved in EX.
REQ-010 E_DivStart  input  1  the EX instruction is DIV/DIVU/REM/REMU.
REQ-011 M_Rd  input  5; M_RegWrite  input  1; W_Rd  input  5; W_RegWrite  input  1.
REQ-012 F_Stall, D_Stall, E_Stall  output  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-013 D_Flush, E_Flush, M_Flush  output  1 each  bubble the IF/ID, ID/EX and EX/MEM registers.
REQ-014 E_ForwardA, E_ForwardB  output  2 each  ALU operand select: 00 register file, 10 MEM result, 01 WB result.
REQ-015 E_DivBusy  output  1 (high while state is BUSY); E_DivDone  output  1 (one-cycle pulse when the result is valid).

Function
REQ-016 SHALL use a state machine with three states: IDLE, BUSY and DONE.
REQ-017 Transitions: IDLE->BUSY when E_DivStart=1; counter loads DIV_CYCLES-2.
REQ-018 Transitions: BUSY decrements the counter each cycle and goes BUSY->DONE when the counter is 0.
REQ-019 Transitions: DONE->IDLE unconditionally; E_DivStart sampled in DONE is ignored, so the same divide is not restarted.
REQ-020 The divide occupies exactly DIV_CYCLES cycles: the IDLE start cycle plus the BUSY cycles, with E_DivDone=1 in the DONE cycle.
REQ-021 In the start cycle and all BUSY cycles: F_Stall=D_Stall=E_Stall=1, M_Flush=1, D_Flush=0 and E_Flush=0.
REQ-022 In DONE all stalls and flushes SHALL be released so the divide advances.
REQ-023 Load-use, applying only when not dividing: E_ResultSrc=01, E_Rd!=0 and E_Rd equal to D_Rs1 or D_Rs2 SHALL give F_Stall=D_Stall=1 and E_Flush=1 in the same cycle (combinational).
REQ-024 Control hazard: E_PCSrc=1 when not dividing SHALL give D_Flush=1 and E_Flush=1.
REQ-025 E_PCSrc and load-use together: flushes OR; F_Stall and D_Stall are still asserted, because the taken redirect overrides via D_Flush.
REQ-026 E_PCSrc SHALL be ignored during the start cycle and BUSY.
REQ-027 Forwarding A: 10 if M_RegWrite, M_Rd!=0 and M_Rd==E_Rs1; else 01 if W_RegWrite, W_Rd!=0 and W_Rd==E_Rs1; else 00. MEM has priority.
REQ-028 Forwarding B: same rule using E_Rs2.
REQ-029 Forwarding SHALL stay active during BUSY.
REQ-030 Register x0 SHALL never trigger forwarding or a load-use stall.

Reset
REQ-031 rst_n=0 SHALL immediately force state to IDLE, counter to 0, E_DivBusy=0 and E_DivDone=0, including in the middle of a divide.
REQ-032 While in reset, all stall and flush outputs SHALL be 0.
REQ-033 After rst_n rises, normal operation SHALL resume on the first clock edge.

Structure
REQ-034 State encodings, the load ResultSrc code 2'b01 and the forward-select codes SHALL live in the shared pipeline package used by the pipeline registers.
REQ-035 One sub-module SHALL be used: div_seq, holding the FSM and counter with outputs busy, done and start_hit; the forwarding and hazard logic SHALL stay combinational at the top level.

Verification
REQ-036 E_ResultSrc=01, E_Rd=5, D_Rs2=5 -> F_Stall=D_Stall=E_Flush=1 that cycle; with E_Rd=0 -> all outputs 0.
REQ-037 M_Rd=W_Rd=E_Rs1=7 with both RegWrite=1 -> E_ForwardA=10; M_RegWrite=0 -> 01; E_Rs1=0 -> 00.
REQ-038 E_DivStart held high with DIV_CYCLES=33 -> stalls and M_Flush high for 32 cycles, E_DivDone high on cycle 33, stalls low on cycle 33, and no restart on cycle 34.
REQ-039 E_PCSrc=1 in BUSY -> no flush; E_PCSrc=1 in IDLE -> D_Flush=E_Flush=1 for one cycle.
REQ-040 rst_n pulsed low at BUSY cycle 10 -> E_DivBusy=0 and all stalls 0 asynchronously; a new E_DivStart afterwards restarts a full 33-cycle count.
